// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle subtractor computing a - b - bin, CHUNK bits
// per clock from the LSB up. Registered results are held in DONE until consumed.
//
// Handshake: operands are accepted on a rising edge where in_valid & in_ready;
// in_ready is high only in IDLE with rst released. The result is offered while
// out_valid is high (DONE only) and is consumed on a rising edge where
// out_valid & out_ready, which returns the block to IDLE. A request presented
// in the same cycle as out_ready in DONE is not taken; it can be accepted one
// edge later, in IDLE.
module chunked_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int STEPS  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject parameter combinations that cannot be split into whole chunks.
  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_subtractor: need WIDTH >= 1, CHUNK >= 1, WIDTH %% CHUNK == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic                borrow_w_q, borrow_w_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]    diff_q, diff_d;
  logic                borrow_q, borrow_d;
  logic                ovf_q, ovf_d;
  logic                zero_q, zero_d;

  logic [31:0]         bit_off;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic [CHUNK-1:0]    a_chunk;
  logic [CHUNK-1:0]    b_chunk;
  logic [CHUNK:0]      chunk_sum;
  logic                chunk_borrow;
  logic [WIDTH-1:0]    work_ins;
  logic                last_step;

  // Current chunk: select operand bits at the step offset and subtract with borrow.
  always_comb begin
    bit_off      = 32'(step_q) * 32'(CHUNK);
    a_sh         = a_q >> bit_off;
    b_sh         = b_q >> bit_off;
    a_chunk      = a_sh[CHUNK-1:0];
    b_chunk      = b_sh[CHUNK-1:0];
    chunk_sum    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_w_q};
    chunk_borrow = chunk_sum[CHUNK];
    work_ins     = (work_q & ~(CHUNK_MASK << bit_off))
                 | (WIDTH'(chunk_sum[CHUNK-1:0]) << bit_off);
    last_step    = (step_q == STEP_W'(STEPS - 1));
  end

  // Next-state and datapath updates; results load only on the RUN->DONE edge.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    work_d     = work_q;
    borrow_w_d = borrow_w_q;
    step_d     = step_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = S_RUN;
          a_d        = in_a;
          b_d        = in_b;
          borrow_w_d = in_bin;
          step_d     = '0;
          work_d     = '0;
        end
      end
      S_RUN: begin
        work_d     = work_ins;
        borrow_w_d = chunk_borrow;
        step_d     = step_q + STEP_W'(1);
        if (last_step) begin
          state_d  = S_DONE;
          diff_d   = work_ins;
          borrow_d = chunk_borrow;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_ins[WIDTH-1] != a_q[WIDTH-1]);
          zero_d   = (work_ins == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      borrow_w_q <= 1'b0;
      step_q     <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      work_q     <= work_d;
      borrow_w_q <= borrow_w_d;
      step_q     <= step_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  // Status and result outputs; in_ready is gated by rst so it drops at once.
  always_comb begin
    in_ready  = rst && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
    diff      = diff_q;
    borrow    = borrow_q;
    ovf       = ovf_q;
    zero      = zero_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor (WIDTH=8, CHUNK=2): reference vectors, handshake
// and reset corner cases, then random operands against an arithmetic model.
module tb_chunked_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_diff;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       br;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs[7];

  chunked_subtractor #(.WIDTH(8), .CHUNK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic br, output logic ov, output logic z);
    int full;
    int sfull;
    full  = int'(a) - int'(b) - int'(bin);
    sfull = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = 8'(full);
    br = (full < 0);
    ov = (sfull < -128) || (sfull > 127);
    z  = (d == 8'h00);
  endtask

  // Present operands and complete the acceptance edge; called off-edge in IDLE.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic bin);
    prev_diff = diff;
    in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_bin = 1'($urandom);
  endtask

  // Wait for out_valid (bounded), check latency and results, then consume.
  task automatic finish_op(input logic ebr, input logic eov, input logic ez, input int ready_delay);
    int edges;
    bit got;
    logic [7:0] ed;
    edges = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) got = 1'b1;
      else check("diff_hold_in_run", 32'(diff), 32'(prev_diff));
    end
    ed = exp_q.pop_front();
    check("latency", 32'(edges), 32'd4);
    check("diff", 32'(diff), 32'(ed));
    check("borrow", 32'(borrow), 32'(ebr));
    check("ovf", 32'(ovf), 32'(eov));
    check("zero", 32'(zero), 32'(ez));
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("diff_hold_done", 32'(diff), 32'(ed));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clear", 32'(out_valid), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic ebr, input logic eov, input logic ez,
                       input int ready_delay);
    exp_q.push_back(ed);
    accept(a, b, bin);
    finish_op(ebr, eov, ez, ready_delay);
  endtask

  initial begin
    logic [7:0] ra, rb, md;
    logic rbin, mbr, mov, mz;
    int held_edges;
    bit seen_valid;

    vecs[0] = '{a:8'h35, b:8'h12, bin:1'b0, d:8'h23, br:1'b0, ov:1'b0, z:1'b0};
    vecs[1] = '{a:8'h00, b:8'h01, bin:1'b0, d:8'hFF, br:1'b1, ov:1'b0, z:1'b0};
    vecs[2] = '{a:8'h80, b:8'h01, bin:1'b0, d:8'h7F, br:1'b0, ov:1'b1, z:1'b0};
    vecs[3] = '{a:8'h7F, b:8'hFF, bin:1'b0, d:8'h80, br:1'b1, ov:1'b1, z:1'b0};
    vecs[4] = '{a:8'h05, b:8'h04, bin:1'b1, d:8'h00, br:1'b0, ov:1'b0, z:1'b1};
    vecs[5] = '{a:8'hFF, b:8'hFF, bin:1'b1, d:8'hFF, br:1'b1, ov:1'b0, z:1'b0};
    vecs[6] = '{a:8'h80, b:8'h7F, bin:1'b1, d:8'h00, br:1'b0, ov:1'b1, z:1'b1};

    // Reset: outputs must be zero with no clock edge having occurred
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({borrow, ovf, zero}), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Table of reference vectors
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].br, vecs[i].ov, vecs[i].z, i % 3);

    // Back-pressure in DONE with in_valid pulsing; nothing may be accepted
    exp_q.push_back(8'h23);
    accept(8'h35, 8'h12, 1'b0);
    held_edges = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      @(posedge clk); #1;
      held_edges++;
      if (out_valid) seen_valid = 1'b1;
    end
    check("bp_latency", 32'(held_edges), 32'd4);
    check("bp_diff", 32'(diff), 32'(exp_q.pop_front()));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 8'($urandom); in_b = 8'($urandom); in_bin = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff_stable", 32'(diff), 32'h23);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b1; in_a = 8'h0A; in_b = 8'h03; in_bin = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_not_accepted_busy", 32'(busy), 32'd0);
    check("exit_in_ready", 32'(in_ready), 32'd1);
    prev_diff = diff;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_after_exit", 32'(busy), 32'd1);
    exp_q.push_back(8'h07);
    finish_op(1'b0, 1'b0, 1'b0, 0);

    // Reset abort in RUN step 2, preceded by a result with nonzero flags
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 0);
    accept(8'h99, 8'h11, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_flags", 32'({borrow, ovf, zero}), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    do_op(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbin, md, mbr, mov, mz);
      do_op(ra, rb, rbin, md, mbr, mov, mz, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
